// File: rtl/sn_api_mlane_ctrlr.sv
// sn_api_mlane_ctrlr
//   Multi-lane Axon Protocol Interface controller. On nc_transmit it snapshots
//   the spike-pending flags of all transmitting neurons (inputs + hidden), then
//   grants up to P_NUM_LANES of them per cycle. Each grant is driven as a neuron
//   index onto its own API bus lane. A single-cycle api_nc_done closes the phase.
//
//   Optional feature macro: SN_API_SPIKE_CNT_EN enables the saturating grant
//   counter on api_spike_cnt. When it is undefined the port is tied to zero.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   nc_transmit    start-of-transmit pulse (accepted only in IDLE)
//   nc_reset       clears the spike counter
//   api_pending    per-neuron spike-pending flags, index 1..L_NUM_SRC
//   api_granted    per-neuron grant flags for the current cycle
//   api_vld        per-lane valid
//   api_bus        per-lane granted neuron index (0 when lane invalid)
//   api_nc_done    one-cycle end-of-transmit pulse
//   api_busy       high while scanning or signalling done
//   api_spike_cnt  saturating count of grants issued
module sn_api_mlane_ctrlr #(
  parameter int P_NUM_NEURONS = 100,
  parameter int P_NUM_INPUTS  = 45,
  parameter int P_NUM_OUTPUTS = 3,
  parameter int P_NUM_LANES   = 2,
  parameter int P_GRANT_MODE  = 0,
  localparam int L_NUM_SRC    = P_NUM_NEURONS - P_NUM_OUTPUTS,
  localparam int L_API_BUS_BW = $clog2(L_NUM_SRC + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        nc_transmit,
  input  logic                                        nc_reset,
  input  logic [L_NUM_SRC:1]                          api_pending,
  output logic [L_NUM_SRC:1]                          api_granted,
  output logic [P_NUM_LANES-1:0]                      api_vld,
  output logic [P_NUM_LANES-1:0][L_API_BUS_BW-1:0]    api_bus,
  output logic                                        api_nc_done,
  output logic                                        api_busy,
  output logic [15:0]                                 api_spike_cnt
);

  localparam int unsigned           L_SRC_U   = unsigned'(L_NUM_SRC);
  localparam int unsigned           L_LANES_U = unsigned'(P_NUM_LANES);
  localparam logic [L_API_BUS_BW:0]   L_SRC_W = (L_API_BUS_BW + 1)'(L_NUM_SRC);
  localparam logic [L_API_BUS_BW-1:0] L_SRC_B = L_API_BUS_BW'(L_NUM_SRC);
  localparam logic [L_API_BUS_BW-1:0] L_ONE_B = L_API_BUS_BW'(1);

  if (P_NUM_LANES < 1 || P_NUM_LANES > 8 || P_NUM_INPUTS > L_NUM_SRC ||
      (P_GRANT_MODE != 0 && P_GRANT_MODE != 1)) begin : g_cfg_err
    $error("sn_api_mlane_ctrlr: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [L_NUM_SRC:1]      pend_q, pend_d;
  logic [L_API_BUS_BW-1:0] rr_ptr_q, rr_ptr_d;

  logic [L_NUM_SRC:1]                       grant;
  logic [P_NUM_LANES-1:0]                   vld;
  logic [P_NUM_LANES-1:0][L_API_BUS_BW-1:0] bus;
  logic [L_API_BUS_BW-1:0]                  last_idx;
  logic                                     any_sel;

  // Lane selector: walk all sources once in search order starting at
  // start_b (wrapping past L_NUM_SRC to 1) and hand the first P_NUM_LANES
  // pending ones to lanes 0, 1, ... in the order they are found.
  always_comb begin
    logic [L_API_BUS_BW-1:0] start_b;
    logic [L_API_BUS_BW:0]   pos;
    logic [L_API_BUS_BW-1:0] idx_b;
    int unsigned             nsel;
    grant    = '0;
    vld      = '0;
    bus      = '0;
    last_idx = '0;
    any_sel  = 1'b0;
    nsel     = 0;
    pos      = '0;
    idx_b    = '0;
    start_b  = (P_GRANT_MODE == 1) ? rr_ptr_q : L_ONE_B;
    if (state_q == ST_SCAN) begin
      for (int unsigned i = 0; i < L_SRC_U; i++) begin
        pos   = {1'b0, start_b} + (L_API_BUS_BW + 1)'(i);
        idx_b = (pos > L_SRC_W) ? L_API_BUS_BW'(pos - L_SRC_W) : L_API_BUS_BW'(pos);
        if (pend_q[idx_b] && (nsel < L_LANES_U)) begin
          grant[idx_b] = 1'b1;
          for (int unsigned k = 0; k < L_LANES_U; k++) begin
            if (k == nsel) begin
              vld[k] = 1'b1;
              bus[k] = idx_b;
            end
          end
          last_idx = idx_b;
          any_sel  = 1'b1;
          nsel     = nsel + 1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (nc_transmit) begin
          pend_d  = api_pending;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        pend_d = pend_q & ~grant;
        if (pend_d == '0) begin
          state_d = ST_DONE;
          // Next window starts just past the last neuron served in this one.
          if (P_GRANT_MODE == 1 && any_sel) begin
            rr_ptr_d = (last_idx == L_SRC_B) ? L_ONE_B : last_idx + L_ONE_B;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      rr_ptr_q <= L_ONE_B;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign api_granted = grant;
  assign api_vld     = vld;
  assign api_bus     = bus;
  assign api_nc_done = (state_q == ST_DONE);
  assign api_busy    = (state_q != ST_IDLE);

`ifdef SN_API_SPIKE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 17'($countones(grant));
    if (nc_reset) begin
      cnt_d = '0;
    end else if (cnt_sum[16]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign api_spike_cnt = cnt_q;
`else
  logic unused_nc_reset;
  assign unused_nc_reset = nc_reset;
  assign api_spike_cnt   = '0;
`endif

endmodule

// File: tb/tb_sn_api_mlane_ctrlr.sv
module tb_sn_api_mlane_ctrlr;

  localparam int NN = 10;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int NL = 2;
  localparam int NS = NN - NO;
  localparam int BW = $clog2(NS + 1);
`ifdef SN_API_SPIKE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    nc_transmit;
  logic                    nc_reset;
  logic [NS:1]             api_pending;
  logic [NS:1]             g0, g1;
  logic [NL-1:0]           v0, v1;
  logic [NL-1:0][BW-1:0]   b0, b1;
  logic                    d0, d1, y0, y1;
  logic [15:0]             c0, c1;

  sn_api_mlane_ctrlr #(
    .P_NUM_NEURONS(NN), .P_NUM_INPUTS(NI), .P_NUM_OUTPUTS(NO),
    .P_NUM_LANES(NL), .P_GRANT_MODE(0)
  ) u_fp (
    .clk(clk), .rst(rst), .nc_transmit(nc_transmit), .nc_reset(nc_reset),
    .api_pending(api_pending), .api_granted(g0), .api_vld(v0), .api_bus(b0),
    .api_nc_done(d0), .api_busy(y0), .api_spike_cnt(c0)
  );

  sn_api_mlane_ctrlr #(
    .P_NUM_NEURONS(NN), .P_NUM_INPUTS(NI), .P_NUM_OUTPUTS(NO),
    .P_NUM_LANES(NL), .P_GRANT_MODE(1)
  ) u_rr (
    .clk(clk), .rst(rst), .nc_transmit(nc_transmit), .nc_reset(nc_reset),
    .api_pending(api_pending), .api_granted(g1), .api_vld(v1), .api_bus(b1),
    .api_nc_done(d1), .api_busy(y1), .api_spike_cnt(c1)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int ord0[$];
  int ord1[$];
  int rr_m     = 1;
  int exp_cnt  = 0;

  // Reference: service order is the snapshot's set indices listed in search
  // order (ascending, or ascending from rr_m with wrap), dealt out NL per cycle.
  task automatic run_txn(input logic [NS:1] p, input bit noisy, input string name);
    int n, ncyc, ng, sz, e, ix;
    logic [NS:1] eg, ag;
    logic [NL-1:0] ev, av;
    logic [NL-1:0][BW-1:0] eb, ab;
    logic ad, ay;
    ord0.delete();
    ord1.delete();
    for (int i = 1; i <= NS; i++) if (p[i]) ord0.push_back(i);
    for (int k = 0; k < NS; k++) begin
      ix = (rr_m - 1 + k) % NS + 1;
      if (p[ix]) ord1.push_back(ix);
    end
    n    = ord0.size();
    ncyc = (n == 0) ? 1 : (n + NL - 1) / NL;
    nc_transmit = 1'b1;
    api_pending = p;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        sz = (m == 0) ? ord0.size() : ord1.size();
        eg = '0; ev = '0; eb = '0;
        for (int k = 0; k < NL; k++) begin
          e = c * NL + k;
          if (e < sz) begin
            ix    = (m == 0) ? ord0[e] : ord1[e];
            ev[k] = 1'b1;
            eb[k] = BW'(ix);
            eg    = eg | (NS'(1) << (ix - 1));
          end
        end
        ag = (m == 0) ? g0 : g1;
        av = (m == 0) ? v0 : v1;
        ab = (m == 0) ? b0 : b1;
        ad = (m == 0) ? d0 : d1;
        ay = (m == 0) ? y0 : y1;
        n_checks++;
        if ({ag, av, ab, ad, ay} !== {eg, ev, eb, 1'b0, 1'b1}) begin
          n_errs++;
          $display("FAIL %s scan mode%0d cyc%0d: got granted=%b vld=%b bus=%h done=%b busy=%b, want granted=%b vld=%b bus=%h done=0 busy=1",
                   name, m, c, ag, av, ab, ad, ay, eg, ev, eb);
        end
      end
      ng = 0;
      for (int k = 0; k < NL; k++) if (c * NL + k < n) ng++;
      n_checks++;
      if (c0 !== 16'(CNT_EN ? exp_cnt : 0) || c1 !== 16'(CNT_EN ? exp_cnt : 0)) begin
        n_errs++;
        $display("FAIL %s spike_cnt cyc%0d: got %0d/%0d, want %0d", name, c, c0, c1,
                 CNT_EN ? exp_cnt : 0);
      end
      exp_cnt = (exp_cnt + ng > 65535) ? 65535 : exp_cnt + ng;
      nc_transmit = noisy ? 1'($urandom) : 1'b0;
      if (noisy) api_pending = NS'($urandom);
    end
    @(negedge clk);
    n_checks++;
    if ({d0, y0, v0, g0, b0, d1, y1, v1, g1, b1} !==
        {1'b1, 1'b1, {NL{1'b0}}, {NS{1'b0}}, {(NL*BW){1'b0}},
         1'b1, 1'b1, {NL{1'b0}}, {NS{1'b0}}, {(NL*BW){1'b0}}}) begin
      n_errs++;
      $display("FAIL %s done_cycle: got done=%b/%b busy=%b/%b vld=%b/%b granted=%b/%b, want done=1 busy=1 vld=0 granted=0",
               name, d0, d1, y0, y1, v0, v1, g0, g1);
    end
    n_checks++;
    if (c0 !== 16'(CNT_EN ? exp_cnt : 0) || c1 !== 16'(CNT_EN ? exp_cnt : 0)) begin
      n_errs++;
      $display("FAIL %s spike_cnt done: got %0d/%0d, want %0d", name, c0, c1, CNT_EN ? exp_cnt : 0);
    end
    nc_transmit = noisy ? 1'($urandom) : 1'b0;
    @(negedge clk);
    n_checks++;
    if ({d0, y0, v0, g0, d1, y1, v1, g1} !== '0) begin
      n_errs++;
      $display("FAIL %s idle_after: got done=%b/%b busy=%b/%b vld=%b/%b granted=%b/%b, want all 0",
               name, d0, d1, y0, y1, v0, v1, g0, g1);
    end
    nc_transmit = 1'b0;
    api_pending = '0;
    if (ord1.size() > 0) rr_m = ord1[ord1.size() - 1] % NS + 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; nc_transmit = 1'b0; nc_reset = 1'b0; api_pending = '0;
    #12;
    n_checks++;
    if ({g0, v0, b0, d0, y0, c0, g1, v1, b1, d1, y1, c1} !== '0) begin
      n_errs++;
      $display("FAIL reset_outputs: got granted=%b/%b vld=%b/%b done=%b/%b busy=%b/%b cnt=%0d/%0d, want all 0",
               g0, g1, v0, v1, d0, d1, y0, y1, c0, c1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    api_pending = NS'($urandom);
    @(negedge clk);
    n_checks++;
    if ({g0, v0, d0, y0, g1, v1, d1, y1} !== '0) begin
      n_errs++;
      $display("FAIL idle_no_transmit: got granted=%b/%b vld=%b/%b busy=%b/%b, want 0", g0, g1, v0, v1, y0, y1);
    end
    api_pending = '0;
  endtask

  task automatic test_rr_windows();
    run_txn(8'b0100_0011, 1'b0, "rr_win1");
    run_txn(8'b1100_0010, 1'b0, "rr_win2");
  endtask

  task automatic test_fixed_pattern();
    run_txn(8'b1010_0110, 1'b0, "pattern_a6");
  endtask

  task automatic test_empty();
    run_txn(8'b0000_0000, 1'b0, "empty");
  endtask

  task automatic test_single();
    run_txn(8'b0001_0000, 1'b0, "single5");
    run_txn(8'b1000_0000, 1'b0, "single8");
    run_txn(8'b1111_1111, 1'b0, "all");
  endtask

  task automatic test_ignore_noise();
    run_txn(8'b0110_1001, 1'b1, "noisy1");
    run_txn(8'b1011_0111, 1'b1, "noisy2");
  endtask

  task automatic test_back_to_back_random();
    int gap;
    for (int t = 0; t < 30; t++) begin
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        n_checks++;
        if ({d0, y0, v0, g0, d1, y1, v1, g1} !== '0) begin
          n_errs++;
          $display("FAIL rand_gap t%0d: got busy=%b/%b vld=%b/%b, want 0", t, y0, y1, v0, v1);
        end
      end
      run_txn(NS'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_scan();
    nc_transmit = 1'b1;
    api_pending = 8'hFF;
    @(negedge clk);
    nc_transmit = 1'b0;
    n_checks++;
    if (v0 !== 2'b11 || v1 !== 2'b11) begin
      n_errs++;
      $display("FAIL rst_mid_pre: got vld=%b/%b, want 11/11", v0, v1);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({g0, v0, b0, d0, y0, c0, g1, v1, b1, d1, y1, c1} !== '0) begin
      n_errs++;
      $display("FAIL rst_mid_async: got granted=%b/%b vld=%b/%b busy=%b/%b cnt=%0d/%0d, want all 0",
               g0, g1, v0, v1, y0, y1, c0, c1);
    end
    @(negedge clk);
    rst = 1'b1;
    api_pending = '0;
    rr_m = 1;
    exp_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_checks++;
      if ({d0, y0, v0, g0, d1, y1, v1, g1} !== '0) begin
        n_errs++;
        $display("FAIL rst_mid_after cyc%0d: got done=%b/%b busy=%b/%b vld=%b/%b, want 0",
                 j, d0, d1, y0, y1, v0, v1);
      end
    end
  endtask

  task automatic test_spike_cnt();
    nc_reset = 1'b1;
    @(negedge clk);
    nc_reset = 1'b0;
    exp_cnt = 0;
    n_checks++;
    if (c0 !== 16'd0 || c1 !== 16'd0) begin
      n_errs++;
      $display("FAIL cnt_clear1: got %0d/%0d, want 0", c0, c1);
    end
    run_txn(8'b0000_1111, 1'b0, "cnt4");
    n_checks++;
    if (c0 !== (CNT_EN ? 16'd4 : 16'd0) || c1 !== (CNT_EN ? 16'd4 : 16'd0)) begin
      n_errs++;
      $display("FAIL cnt_four: got %0d/%0d, want %0d", c0, c1, CNT_EN ? 4 : 0);
    end
    nc_reset = 1'b1;
    @(negedge clk);
    nc_reset = 1'b0;
    exp_cnt = 0;
    n_checks++;
    if (c0 !== 16'd0 || c1 !== 16'd0) begin
      n_errs++;
      $display("FAIL cnt_clear2: got %0d/%0d, want 0", c0, c1);
    end
  endtask

  initial begin
    test_reset();
    test_rr_windows();
    test_fixed_pattern();
    test_empty();
    test_single();
    test_ignore_noise();
    test_back_to_back_random();
    test_reset_mid_scan();
    test_rr_windows();
    test_spike_cnt();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sn_api_mlane_ctrlr.md
# sn_api_mlane_ctrlr

Multi-lane Axon Protocol Interface (API) controller for the spiking network; successor to the single-lane API controller. During each network transmit phase it snapshots the spike-pending flags of all input and hidden neurons, grants up to P_NUM_LANES neurons per cycle, and drives each granted neuron index onto a dedicated API bus lane. It sits between the network controller (transmit/done handshake) and the neuron array (pending/granted), and replaces per-neuron bus driving with controller-driven lanes.

## Interface
- P_NUM_NEURONS, 100: total neurons, including inputs and outputs.
- P_NUM_INPUTS, 45: input neuron count.
- P_NUM_OUTPUTS, 3: output neuron count. Output neurons never transmit.
- P_NUM_LANES, 2: parallel API bus lanes; 1..8.
- P_GRANT_MODE, 0: 0 = fixed priority (lowest index first); 1 = round-robin.
- L_NUM_SRC (local) = P_NUM_NEURONS-P_NUM_OUTPUTS; L_API_BUS_BW (local) = $clog2(L_NUM_SRC+1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- nc_transmit  in  1  single-cycle start-of-transmit pulse from the network controller.
- nc_reset  in  1  clears the spike counter.
- api_pending  in  [L_NUM_SRC:1]  per-neuron spike-pending flags.
- api_granted  out  [L_NUM_SRC:1]  grant flags; one bit per neuron granted this cycle.
- api_vld  out  [P_NUM_LANES-1:0]  per-lane valid.
- api_bus  out  [P_NUM_LANES-1:0][L_API_BUS_BW-1:0]  per-lane neuron index; 0 when the lane is invalid.
- api_nc_done  out  1  single-cycle pulse at the end of transmit.
- api_busy  out  1  high in SCAN and DONE.
- api_spike_cnt  out  16  saturating grant count (see Configuration).

## Operation
- State machine: IDLE, SCAN, DONE.
- IDLE:
  - nc_transmit=1 → pend_q <= api_pending; go to SCAN.
- SCAN:
  - Each cycle, select up to P_NUM_LANES set bits of pend_q, in search order.
  - Lane k carries the (k+1)-th selected index. Lanes are filled from 0 upward; unused lanes have vld=0 and bus=0.
  - The selected bits are set in api_granted and cleared from pend_q at the clock edge.
  - If pend_q has no remaining bits after the edge (including an empty snapshot) → go to DONE.
- DONE:
  - api_nc_done=1 for this one cycle; go to IDLE.
- Search order:
  - Mode 0: index 1 upward.
  - Mode 1: from rr_ptr upward, wrapping from L_NUM_SRC back to 1. On each SCAN→DONE transition, rr_ptr <= (last granted index)+1, wrapping to 1 past L_NUM_SRC. rr_ptr is unchanged if nothing was granted.
- Index 0 is reserved and is never granted.
- api_vld, api_bus and api_granted are combinational from state and pend_q. They are nonzero only in SCAN.
- api_pending changes during SCAN/DONE are ignored; only the snapshot is served.
- nc_transmit outside IDLE is ignored; it is not queued.

## Timing
- Reset values:
  - Outputs: all 0.
  - State IDLE, pend_q=0, rr_ptr=1, counter=0.
- With nc_transmit in cycle T and n snapshot bits:
  - Grants occur in cycles T+1 .. T+ceil(n/P_NUM_LANES).
  - api_nc_done is asserted in the following cycle.
  - n=0 → SCAN in cycle T+1 with no grants; api_nc_done in cycle T+2.
- api_busy is high from T+1 through the api_nc_done cycle inclusive.
- Earliest next accepted nc_transmit: the cycle after api_nc_done.
- Reset asserted mid-SCAN: all outputs are 0 immediately (asynchronous); the remaining snapshot is discarded; no api_nc_done is issued.

## Configuration
- SN_API_SPIKE_CNT_EN defined:
  - api_spike_cnt += popcount(api_granted) each cycle, saturating at 16'hFFFF.
  - nc_reset=1 clears it to 0; clear wins over a simultaneous increment.
- Not defined: api_spike_cnt is tied to 0; the port remains so integration is unchanged.

## Test plan
Bench configuration: P_NUM_NEURONS=10, P_NUM_INPUTS=4, P_NUM_OUTPUTS=2 → sources 1..8, bus width 4; P_NUM_LANES=2.
- Mode 0, pending=8'b1010_0110, nc_transmit in T → T+1: lanes {2,3}; T+2: lanes {6,8}; api_nc_done in T+3; api_granted one-hot per lane each cycle.
- Pending=0, nc_transmit in T → no api_vld; api_nc_done in T+2; api_busy high in T+1 and T+2.
- Pending={5} → T+1: lane0=5, api_vld=2'b01, api_bus[1]=0; api_nc_done in T+2.
- Mode 1, first window {1,2,7} → {1,2}, then {7}; rr_ptr=8. Second window {2,7,8} → {8,2}, then {7}.
- Pending toggles during SCAN plus a second nc_transmit mid-SCAN → only the original snapshot is granted; exactly one api_nc_done.
- rst low in the cycle of the first grant → outputs 0 and no api_nc_done. With SN_API_SPIKE_CNT_EN: 4 grants → api_spike_cnt=4; nc_reset → 0.
